// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Decodes a byte stream from the UART receiver into register accesses.
//   A command byte carries the operation in bit 7 (1 = write, 0 = read) and
//   the register address in bits [6:0]. Writes collect REG_WIDTH payload
//   bytes and issue one register write strobe. Reads fetch one register and
//   stream its bytes into the TX FIFO, stalling while the FIFO is full.
//
// Ports
//   clk          system clock
//   i_reset      asynchronous, active-high reset
//   i_data       received byte
//   i_dv         one-cycle strobe, i_data valid
//   o_reg_addr   register address
//   o_reg_wdata  register write data
//   o_reg_we     one-cycle register write strobe
//   o_reg_re     one-cycle register read strobe
//   i_reg_rdata  register read data, valid one cycle after o_reg_re
//   o_tx_data    byte towards the TX FIFO
//   o_tx_w_en    TX FIFO write enable
//   i_tx_full    TX FIFO full
//   o_busy       high whenever a command is in progress
//   o_err        one-cycle error pulse
//   o_err_count  saturating error counter
module uart_reg_bridge #(
  parameter int REG_DEPTH     = 16,
  parameter int REG_WIDTH     = 4,
  parameter bit LITTLE_ENDIAN = 1'b0,
  parameter int TIMEOUT       = 43400,
  localparam int AW = $clog2(REG_DEPTH),
  localparam int DW = 8 * REG_WIDTH
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic [7:0]    i_data,
  input  logic          i_dv,
  output logic [AW-1:0] o_reg_addr,
  output logic [DW-1:0] o_reg_wdata,
  output logic          o_reg_we,
  output logic          o_reg_re,
  input  logic [DW-1:0] i_reg_rdata,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_w_en,
  input  logic          i_tx_full,
  output logic          o_busy,
  output logic          o_err,
  output logic [7:0]    o_err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(REG_WIDTH + 1);
  localparam logic [7:0] DEPTH8 = 8'(REG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRITE,
    S_RD_REQ,
    S_RD_LATCH,
    S_SEND
  } state_t;

  state_t        r_state;
  logic [6:0]    r_cmdAddr;
  logic [DW-1:0] r_shift;
  logic [CW-1:0] r_byteCnt;
  logic [TW-1:0] r_timer;

  logic          w_inRange;
  logic          w_cmdInRange;
  logic          w_lastByte;
  logic          w_timeout;
  logic          w_overrun;
  logic          w_badWrite;
  logic          w_badRead;
  logic          w_errEvent;
  logic [DW-1:0] w_shiftIn;
  logic [DW-1:0] w_shiftOut;

  // Address range checks: the latched command address for the later states,
  // and the raw incoming byte for the read strobe issued straight from IDLE.
  assign w_inRange    = ({1'b0, r_cmdAddr} < DEPTH8);
  assign w_cmdInRange = ({1'b0, i_data[6:0]} < DEPTH8);
  assign w_lastByte   = (r_byteCnt == CW'(REG_WIDTH - 1));

  // One shared shift register assembles the write payload and later streams
  // the read response; the byte order flips the shift direction.
  assign w_shiftIn  = LITTLE_ENDIAN ? ((r_shift >> 8) | (DW'(i_data) << (DW - 8)))
                                    : ((r_shift << 8) | DW'(i_data));
  assign w_shiftOut = LITTLE_ENDIAN ? (r_shift >> 8) : (r_shift << 8);

  // All error sources are merged so coincident errors give a single pulse
  // and a single counter increment.
  assign w_timeout  = (r_state == S_WDATA) && !i_dv && (r_timer == TW'(TIMEOUT));
  assign w_overrun  = i_dv && (r_state inside {S_WRITE, S_RD_REQ, S_RD_LATCH, S_SEND});
  assign w_badWrite = (r_state == S_WDATA) && i_dv && w_lastByte && !w_inRange;
  assign w_badRead  = (r_state == S_RD_REQ) && !w_inRange;
  assign w_errEvent = w_timeout | w_overrun | w_badWrite | w_badRead;

  // The TX handshake is combinational so a byte is never pushed into a
  // full FIFO, even on the cycle the full flag rises.
  assign o_tx_data = LITTLE_ENDIAN ? r_shift[7:0] : r_shift[DW-1 -: 8];
  assign o_tx_w_en = (r_state == S_SEND) && !i_tx_full;
  assign o_busy    = (r_state != S_IDLE);

  // Command FSM. Strobes are registered on the transition into the state
  // they belong to, so o_reg_we is high during WRITE and o_reg_re during
  // RD_REQ, one cycle after the byte that triggered them.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cmdAddr   <= '0;
      r_shift     <= '0;
      r_byteCnt   <= '0;
      r_timer     <= '0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_reg_we    <= 1'b0;
      o_reg_re    <= 1'b0;
      o_err       <= 1'b0;
      o_err_count <= '0;
    end else begin
      o_reg_we <= 1'b0;
      o_reg_re <= 1'b0;
      o_err    <= w_errEvent;
      if (w_errEvent && (o_err_count != 8'hFF)) begin
        o_err_count <= o_err_count + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_dv) begin
            r_cmdAddr  <= i_data[6:0];
            o_reg_addr <= i_data[AW-1:0];
            if (i_data[7]) begin
              r_state   <= S_WDATA;
              r_byteCnt <= '0;
              r_timer   <= '0;
            end else begin
              r_state  <= S_RD_REQ;
              o_reg_re <= w_cmdInRange;
            end
          end
        end

        S_WDATA: begin
          if (i_dv) begin
            r_shift <= w_shiftIn;
            r_timer <= '0;
            if (w_lastByte) begin
              r_state  <= S_WRITE;
              o_reg_we <= w_inRange;
              if (w_inRange) begin
                o_reg_wdata <= w_shiftIn;
              end
            end else begin
              r_byteCnt <= r_byteCnt + CW'(1);
            end
          end else if (r_timer == TW'(TIMEOUT)) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        S_WRITE: begin
          r_state <= S_IDLE;
        end

        S_RD_REQ: begin
          r_state <= S_RD_LATCH;
        end

        S_RD_LATCH: begin
          r_shift   <= w_inRange ? i_reg_rdata : {REG_WIDTH{8'hEE}};
          r_byteCnt <= '0;
          r_state   <= S_SEND;
        end

        S_SEND: begin
          if (!i_tx_full) begin
            r_shift <= w_shiftOut;
            if (w_lastByte) begin
              r_state <= S_IDLE;
            end else begin
              r_byteCnt <= r_byteCnt + CW'(1);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge
//   Drives uart_reg_bridge with directed command sequences followed by a
//   randomized byte stream. A transaction-level model predicts every output
//   each cycle; directed sections also pin results to literal values. A second
//   instance with little-endian byte order shares the stimulus.
module tb_uart_reg_bridge;

  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_data;
  logic        i_dv;
  logic        i_tx_full;
  logic [31:0] i_reg_rdata;

  logic [3:0]  o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic        o_reg_we, o_reg_re, o_tx_w_en, o_busy, o_err;
  logic [7:0]  o_tx_data, o_err_count;

  logic [31:0] leRdata = 32'hAABBCCDD;
  logic [3:0]  leAddr;
  logic [31:0] leWdata;
  logic        leWe, leRe, leTxEn, leBusy, leErr;
  logic [7:0]  leTxData, leCount;

  int nChecks = 0;
  int nPass   = 0;

  uart_reg_bridge #(.REG_DEPTH(16), .REG_WIDTH(4), .LITTLE_ENDIAN(1'b0), .TIMEOUT(TO)) dut (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
    .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata), .o_reg_we(o_reg_we),
    .o_reg_re(o_reg_re), .i_reg_rdata(i_reg_rdata), .o_tx_data(o_tx_data),
    .o_tx_w_en(o_tx_w_en), .i_tx_full(i_tx_full), .o_busy(o_busy),
    .o_err(o_err), .o_err_count(o_err_count)
  );

  uart_reg_bridge #(.REG_DEPTH(16), .REG_WIDTH(4), .LITTLE_ENDIAN(1'b1), .TIMEOUT(TO)) dutLe (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
    .o_reg_addr(leAddr), .o_reg_wdata(leWdata), .o_reg_we(leWe),
    .o_reg_re(leRe), .i_reg_rdata(leRdata), .o_tx_data(leTxData),
    .o_tx_w_en(leTxEn), .i_tx_full(i_tx_full), .o_busy(leBusy),
    .o_err(leErr), .o_err_count(leCount)
  );

  always #5 clk = ~clk;

  // Register file contents as seen by the bridge; written by the model on
  // each committed in-range write.
  logic [31:0] mem [16];

  // Model state: payload collection, a read's age in cycles since its
  // command, and the bytes still owed to the TX FIFO.
  bit          mCollect = 1'b0;
  logic [7:0]  mPay[$];
  int          mQuiet = 0;
  logic [6:0]  mCmd = '0;
  bit          mCommit = 1'b0;
  int          mRdAge = 0;
  logic [7:0]  mTx[$];

  bit          eWe = 1'b0, eRe = 1'b0, eErr = 1'b0, eBusy = 1'b0;
  logic [7:0]  eCount = '0;
  logic [3:0]  eAddr = '0;
  logic [31:0] eWdata = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] data, input logic full);
    @(negedge clk);
    i_dv      = dv;
    i_data    = data;
    i_tx_full = full;
  endtask

  // Behavioural model: advances once per clock from the inputs of the cycle
  // that just ended and publishes what the outputs must be next cycle.
  initial begin
    forever begin
      @(posedge clk or posedge i_reset);
      if (i_reset) begin
        mCollect = 0; mPay.delete(); mQuiet = 0; mCmd = '0; mCommit = 0;
        mRdAge = 0; mTx.delete();
        eWe = 0; eRe = 0; eErr = 0; eBusy = 0; eCount = '0; eAddr = '0; eWdata = '0;
      end else begin
        bit err, nWe, nRe, inR;
        logic [31:0] word, src;
        err = 0; nWe = 0; nRe = 0;
        inR = (mCmd < 7'd16);
        if (!mCollect && !mCommit && mRdAge == 0) begin
          if (i_dv) begin
            mCmd  = i_data[6:0];
            eAddr = i_data[3:0];
            if (i_data[7]) begin
              mCollect = 1; mPay.delete(); mQuiet = 0;
            end else begin
              mRdAge = 1;
              nRe = (i_data[6:0] < 7'd16);
            end
          end
        end else if (mCollect) begin
          if (i_dv) begin
            mPay.push_back(i_data);
            mQuiet = 0;
            if (mPay.size() == 4) begin
              mCollect = 0;
              mCommit = 1;
              word = 0;
              for (int i = 0; i < 4; i++) word = word | (32'(mPay[i]) << (8 * (3 - i)));
              if (inR) begin
                nWe = 1; eWdata = word; mem[mCmd[3:0]] = word;
              end else begin
                err = 1;
              end
            end
          end else if (mQuiet == TO) begin
            mCollect = 0;
            err = 1;
          end else begin
            mQuiet++;
          end
        end else begin
          if (i_dv) err = 1;
          if (mCommit) begin
            mCommit = 0;
          end else if (mRdAge == 1) begin
            mRdAge = 2;
            if (!inR) err = 1;
          end else if (mRdAge == 2) begin
            mRdAge = 3;
            src = inR ? mem[mCmd[3:0]] : 32'hEEEEEEEE;
            mTx.delete();
            for (int i = 0; i < 4; i++) mTx.push_back(8'(src >> (8 * (3 - i))));
          end else if (mRdAge == 3) begin
            if (!i_tx_full) void'(mTx.pop_front());
            if (mTx.size() == 0) mRdAge = 0;
          end
        end
        eWe  = nWe;
        eRe  = nRe;
        eErr = err;
        if (err && eCount != 8'hFF) eCount = eCount + 8'd1;
        eBusy = mCollect || mCommit || (mRdAge != 0);
      end
    end
  end

  // Register-file responder: read data is valid only in the cycle after a
  // read strobe; every other cycle carries noise.
  initial begin
    bit reSeen;
    logic [3:0] reAddr;
    reSeen = 0; reAddr = '0;
    forever begin
      @(negedge clk);
      i_reg_rdata = reSeen ? mem[reAddr] : $urandom;
      reSeen = o_reg_re;
      reAddr = o_reg_addr;
    end
  end

  // Per-cycle comparison against the model, taken mid-cycle once inputs
  // and registered outputs have settled.
  initial begin
    logic [7:0] expTx;
    bit expEn;
    forever begin
      @(negedge clk);
      #1;
      expEn = (mRdAge == 3) && !i_tx_full;
      expTx = (mTx.size() > 0) ? mTx[0] : 8'h00;
      checkOutput("we", 32'(o_reg_we), 32'(eWe));
      checkOutput("re", 32'(o_reg_re), 32'(eRe));
      checkOutput("err", 32'(o_err), 32'(eErr));
      checkOutput("errCount", 32'(o_err_count), 32'(eCount));
      checkOutput("busy", 32'(o_busy), 32'(eBusy));
      checkOutput("txEn", 32'(o_tx_w_en), 32'(expEn));
      if (expEn) checkOutput("txData", 32'(o_tx_data), 32'(expTx));
      if (eWe || eRe) checkOutput("addr", 32'(o_reg_addr), 32'(eAddr));
      if (eWe) checkOutput("wdata", o_reg_wdata, eWdata);
    end
  end

  // Directed scenarios with literal expectations, then random traffic.
  initial begin
    logic [7:0] bigBytes [4];
    logic [7:0] leBytes [4];
    logic [7:0] got[$];
    int fullWrites, errPulses;
    bit weSeen, txSeen;
    logic [7:0] d;

    bigBytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    leBytes  = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    i_reset = 0; i_dv = 0; i_data = 0; i_tx_full = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    #1 i_reset = 1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst we", 32'(o_reg_we), 0);
    checkOutput("rst re", 32'(o_reg_re), 0);
    checkOutput("rst err", 32'(o_err), 0);
    checkOutput("rst count", 32'(o_err_count), 0);
    checkOutput("rst busy", 32'(o_busy), 0);
    checkOutput("rst txEn", 32'(o_tx_w_en), 0);
    checkOutput("rst txData", 32'(o_tx_data), 0);
    checkOutput("rst addr", 32'(o_reg_addr), 0);
    checkOutput("rst wdata", o_reg_wdata, 0);
    @(negedge clk);
    i_reset = 0;

    $display("[TB] write 83 AA BB CC DD");
    applyStimulus(1, 8'h83, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, bigBytes[i], 0);
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("wr we", 32'(o_reg_we), 1);
    checkOutput("wr addr", 32'(o_reg_addr), 3);
    checkOutput("wr wdata", o_reg_wdata, 32'hAABBCCDD);
    checkOutput("wr le wdata", leWdata, 32'hDDCCBBAA);
    checkOutput("wr count", 32'(o_err_count), 0);

    $display("[TB] read 03");
    applyStimulus(1, 8'h03, 0);
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("rd re", 32'(o_reg_re), 1);
    checkOutput("rd addr", 32'(o_reg_addr), 3);
    applyStimulus(0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 8'h00, 0); #1;
      checkOutput("rd txEn", 32'(o_tx_w_en), 1);
      checkOutput("rd txData", 32'(o_tx_data), 32'(bigBytes[i]));
      checkOutput("rd le txData", 32'(leTxData), 32'(leBytes[i]));
    end
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("rd done txEn", 32'(o_tx_w_en), 0);
    checkOutput("rd done busy", 32'(o_busy), 0);

    $display("[TB] read 03 with backpressure");
    applyStimulus(1, 8'h03, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);
    got.delete(); fullWrites = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(0, 8'h00, (k >= 1 && k <= 5)); #1;
      if (o_tx_w_en) begin
        got.push_back(o_tx_data);
        if (i_tx_full) fullWrites++;
      end
    end
    checkOutput("bp pulses", 32'(got.size()), 4);
    checkOutput("bp while full", 32'(fullWrites), 0);
    for (int i = 0; i < 4; i++) checkOutput("bp byte", (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(bigBytes[i]));

    $display("[TB] write timeout");
    applyStimulus(1, 8'h85, 0);
    applyStimulus(1, 8'hAA, 0);
    applyStimulus(1, 8'hBB, 0);
    weSeen = 0; errPulses = 0;
    for (int k = 0; k < TO + 1; k++) begin
      applyStimulus(0, 8'h00, 0); #1;
      weSeen |= o_reg_we;
      errPulses += int'(o_err);
    end
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("to early err", 32'(errPulses), 0);
    checkOutput("to err", 32'(o_err), 1);
    checkOutput("to count", 32'(o_err_count), 1);
    checkOutput("to busy", 32'(o_busy), 0);
    checkOutput("to no we", 32'(weSeen), 0);
    applyStimulus(1, 8'h05, 0);
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("to next re", 32'(o_reg_re), 1);
    checkOutput("to next addr", 32'(o_reg_addr), 5);
    repeat (7) applyStimulus(0, 8'h00, 0);

    $display("[TB] byte on the timeout cycle");
    applyStimulus(1, 8'h86, 0);
    applyStimulus(1, 8'h11, 0);
    repeat (TO) applyStimulus(0, 8'h00, 0);
    applyStimulus(1, 8'h22, 0);
    applyStimulus(1, 8'h33, 0);
    applyStimulus(1, 8'h44, 0);
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("edge we", 32'(o_reg_we), 1);
    checkOutput("edge addr", 32'(o_reg_addr), 6);
    checkOutput("edge wdata", o_reg_wdata, 32'h11223344);
    checkOutput("edge count", 32'(o_err_count), 1);

    $display("[TB] out-of-range read 20 and write A0");
    applyStimulus(1, 8'h20, 0);
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("oor re", 32'(o_reg_re), 0);
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("oor rd err", 32'(o_err), 1);
    checkOutput("oor rd count", 32'(o_err_count), 2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 8'h00, 0); #1;
      checkOutput("oor txEn", 32'(o_tx_w_en), 1);
      checkOutput("oor txData", 32'(o_tx_data), 32'hEE);
    end
    applyStimulus(0, 8'h00, 0);
    applyStimulus(1, 8'hA0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(1, 8'(i), 0);
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("oor we", 32'(o_reg_we), 0);
    checkOutput("oor wr err", 32'(o_err), 1);
    checkOutput("oor wr count", 32'(o_err_count), 3);
    applyStimulus(0, 8'h00, 0); #1;
    checkOutput("oor wr busy", 32'(o_busy), 0);

    $display("[TB] reset during response");
    applyStimulus(1, 8'h03, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 8'h00, 0); #1;
      checkOutput("mid txData", 32'(o_tx_data), 32'(bigBytes[i]));
    end
    @(negedge clk);
    i_reset = 1;
    #1;
    checkOutput("mid rst txEn", 32'(o_tx_w_en), 0);
    checkOutput("mid rst txData", 32'(o_tx_data), 0);
    checkOutput("mid rst busy", 32'(o_busy), 0);
    checkOutput("mid rst count", 32'(o_err_count), 0);
    checkOutput("mid rst addr", 32'(o_reg_addr), 0);
    checkOutput("mid rst wdata", o_reg_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    i_reset = 0;
    txSeen = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 8'h00, 0); #1;
      txSeen |= o_tx_w_en;
    end
    checkOutput("post rst tx", 32'(txSeen), 0);
    checkOutput("post rst busy", 32'(o_busy), 0);

    $display("[TB] random traffic");
    for (int k = 0; k < 4000; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 4) != 0) d[6:4] = 3'b000;
      applyStimulus(($urandom_range(0, 5) == 0), d, ($urandom_range(0, 3) == 0));
    end
    repeat (TO + 10) applyStimulus(0, 8'h00, 0);
    #2;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-stream command decoder between the UART receive path and the register file, with a read-response path into the UART transmit FIFO. Consumes bytes from the receiver (`o_data`/`o_data_valid` of `uart_rx`) and decodes read/write commands. Writes assemble a full register word and issue a one-cycle register write; reads fetch one register and push its bytes into the `fifo_uart` write port, honouring `o_full` backpressure.

## Interface
- `REG_DEPTH`, 16: number of registers; address width `AW = $clog2(REG_DEPTH)`, must be ≤ 7.
- `REG_WIDTH`, 4: register width in bytes; data width `DW = 8*REG_WIDTH`.
- `LITTLE_ENDIAN`, 0: 0 = first data byte is the MSB, 1 = first data byte is the LSB; applies to both write payload and read response.
- `TIMEOUT`, 43400: maximum clocks between consecutive write-payload bytes (about 10 byte times at divisor 434).

Ports:
- `clk  in  1`  system clock.
- `i_reset  in  1`  asynchronous, active-high reset.
- `i_data  in  8`  received byte.
- `i_dv  in  1`  one-cycle strobe; `i_data` is valid.
- `o_reg_addr  out  AW`  register address.
- `o_reg_wdata  out  DW`  register write data.
- `o_reg_we  out  1`  one-cycle write strobe.
- `o_reg_re  out  1`  one-cycle read strobe.
- `i_reg_rdata  in  DW`  read data, valid exactly 1 cycle after `o_reg_re`.
- `o_tx_data  out  8`  byte to the TX FIFO.
- `o_tx_w_en  out  1`  TX FIFO write enable.
- `i_tx_full  in  1`  TX FIFO full.
- `o_busy  out  1`  high in any state other than IDLE.
- `o_err  out  1`  one-cycle error pulse.
- `o_err_count  out  8`  saturating error counter; holds at 255.

## Operation
- Command byte: bit7 = 1 for write, 0 for read. Bits[6:0] are the address.
  - The address is out of range if bits[6:0] ≥ REG_DEPTH.
  - `o_reg_addr` takes bits[AW-1:0].
- States: IDLE, WDATA, WRITE, RD_REQ, RD_LATCH, SEND.
- IDLE:
  - On `i_dv` with a write command, go to WDATA; the byte counter and timeout counter are cleared.
  - On `i_dv` with a read command, go to RD_REQ.
- WDATA:
  - Each `i_dv` shifts the byte into the word according to `LITTLE_ENDIAN`.
  - After REG_WIDTH bytes, go to WRITE.
  - If the timeout counter reaches TIMEOUT with no `i_dv`, pulse `o_err` and return to IDLE. The partial word is discarded.
- WRITE:
  - If the address is in range, assert `o_reg_we` for 1 cycle. Otherwise suppress `o_reg_we` and pulse `o_err`.
  - Return to IDLE.
- RD_REQ:
  - If the address is in range, assert `o_reg_re` for 1 cycle.
  - Go to RD_LATCH.
- RD_LATCH:
  - Capture `i_reg_rdata` into the shift register, or 8'hEE in every byte if the address is out of range (with an `o_err` pulse).
  - Go to SEND.
- SEND:
  - Each cycle with `!i_tx_full`, assert `o_tx_w_en` with the next byte (order per `LITTLE_ENDIAN`).
  - With `i_tx_full` high, hold `o_tx_w_en` low and hold the byte.
  - After REG_WIDTH bytes, return to IDLE.
- Overrun: `i_dv` during WRITE, RD_REQ, RD_LATCH or SEND drops the byte and pulses `o_err`.
- Each `o_err` pulse increments `o_err_count`. If two error sources fire in the same cycle, the count increments by 1.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation aborts:
  - no write is committed;
  - remaining response bytes are not sent.
- Write: if the last payload `i_dv` is at cycle M, then `o_reg_we`, `o_reg_addr` and `o_reg_wdata` are valid at M+1. `i_dv` at M+2 is accepted as a new command.
- Read, with the command `i_dv` at cycle N:
  - `o_reg_re` at N+1;
  - rdata captured at N+2;
  - first `o_tx_w_en` at N+3 if not full;
  - the last byte at N+2+REG_WIDTH with no backpressure.
- `i_tx_full` is sampled combinationally in the same cycle as `o_tx_w_en`. A write is never issued while full.
- Timeout counter: resets on each accepted `i_dv` in WDATA. The abort happens on the cycle the count equals TIMEOUT. A byte arriving on that same cycle wins, and there is no abort.

## Test plan
- Write 8'h83, AA, BB, CC, DD (LITTLE_ENDIAN=0) → one `o_reg_we` with addr 3 and wdata 32'hAABBCCDD, one cycle after the DD strobe; `o_err_count` stays 0.
- Read 8'h03 with the register returning 32'hAABBCCDD → TX bytes AA, BB, CC, DD on 4 consecutive cycles starting N+3. With LITTLE_ENDIAN=1 → DD, CC, BB, AA.
- Read with `i_tx_full` held high for 5 cycles after the first byte → exactly 4 `o_tx_w_en` pulses, byte order intact, none while full.
- Write 8'h85 (addr 5), send 2 data bytes, then wait TIMEOUT+1 clocks → no `o_reg_we`, one `o_err`, count = 1, `o_busy` low. The next command is decoded normally.
- Out-of-range read 8'h20 (REG_DEPTH=16) → no `o_reg_re`, TX EE, EE, EE, EE, one `o_err`. Out-of-range write 8'hA0 + 4 bytes → no `o_reg_we`, one `o_err`.
- Reset asserted mid-SEND after 2 bytes → all outputs 0 immediately, no further TX bytes, IDLE after release.
